color_frame_stats: RTL and testbench
====================================

COLOR_FRAME_STATS -- requirements
Module: color_frame_stats

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 15, pixel address width; FRAME_PIX, 19200, pixels per frame; H_RES, 160, pixels per line; THR, 4, dominance margin in 4-bit colour units.
REQ-002 Ports SHALL be (name direction width meaning): CAM_pclk in 1 sole clock; rst in 1 asynchronous active-low reset; px_vsync in 1 camera vsync; px_we in 1 pixel-write strobe; px_data in 12 pixel {R[11:8],G[7:4],B[3:0]}; sel_color in 2 bounding-box target colour; res_ack in 1 result acknowledge.
REQ-003 Output ports SHALL be: res_valid out 1 result pending; res_color out 2 dominant colour; cnt_r/cnt_g/cnt_b out AW each, per-colour pixel counts; res_short out 1 frame under FRAME_PIX; res_long out 1 frame over FRAME_PIX; res_ovr out 1 result overwritten unacked; bb_xmin/bb_xmax out 8; bb_ymin/bb_ymax out 7; bb_valid out 1.

Function
REQ-004 Colour encoding SHALL be 0 none, 1 red, 2 green, 3 blue.
REQ-005 A pixel SHALL classify red iff R>=G+THR and R>=B+THR, green and blue analogously, else none; comparisons SHALL use 5-bit arithmetic (no wrap).
REQ-006 States SHALL be IDLE, ACCUM, PUBLISH; reset enters IDLE.
REQ-007 Vsync rising edge SHALL be px_vsync=1 with registered previous sample=0.
REQ-008 IDLE -> ACCUM on vsync rising edge; pixels in IDLE SHALL be ignored.
REQ-009 ACCUM: each px_we cycle SHALL increment pixel count and the matching colour counter; x SHALL run 0..H_RES-1, then wrap to 0 and increment y.
REQ-010 Pixel writes beyond FRAME_PIX in one frame SHALL not be counted and SHALL set the frame's long flag.
REQ-011 ACCUM -> PUBLISH on vsync rising edge; px_we in that same cycle SHALL count toward the closing frame.
REQ-012 PUBLISH SHALL last one cycle: latch counts, flags and bbox into outputs, set res_valid, clear accumulators and x/y, return to ACCUM; outputs SHALL update at the edge ending PUBLISH.
REQ-013 Pixel writes during PUBLISH SHALL count toward the new frame at x=0,y=0.
REQ-014 res_color SHALL be the largest of cnt_r/cnt_g/cnt_b, ties resolved R>G>B; all zero yields 0.
REQ-015 res_short SHALL be 1 iff the published frame held fewer than FRAME_PIX pixels.
REQ-016 res_valid SHALL hold until a cycle with res_ack=1, then clear; res_ack with res_valid=0 SHALL have no effect.
REQ-017 PUBLISH with res_valid=1 and no ack SHALL overwrite results and set res_ovr; res_ovr SHALL clear with res_valid on ack.
REQ-018 PUBLISH coinciding with res_ack SHALL leave res_valid=1 and res_ovr=0.
REQ-019 Result outputs SHALL change only at PUBLISH or reset.

Reset
REQ-020 rst low SHALL asynchronously force IDLE, all counters, flags, res_valid, bb_valid and vsync history to 0, bb_xmin/bb_ymin to all-ones, bb_xmax/bb_ymax to 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; the next frame begins only after a new vsync rising edge.

Configuration
REQ-022 Macro CFS_BBOX_EN defined SHALL enable min/max x,y tracking of pixels classified as sel_color (sampled per pixel), bb_valid=1 iff at least one match in the published frame.
REQ-023 Without CFS_BBOX_EN, bbox ports SHALL remain present and tie to 0, bb_valid to 0; all other behaviour unchanged.

Structure
REQ-024 Colour codes, FRAME_PIX, H_RES, V_RES=120 and THR defaults SHALL live in shared package cfs_pkg.
REQ-025 Classification SHALL be a combinational sub-module px_classify (px_data, THR -> 2-bit colour).

Verification
REQ-026 Frame of 19200 pixels 0xF00 between vsync edges -> res_color=1, cnt_r=19200, res_short=0, res_long=0, res_valid 2 edges after vsync first sampled high.
REQ-027 Pixels 0x880 (R=G) -> class 0; 0x840, THR=4 -> red; cnt_g=0 for both.
REQ-028 Frame of 100 pixels, 50 green and 50 blue -> res_color=2, res_short=1.
REQ-029 Two frames published without res_ack -> second frame's counts, res_ovr=1; ack -> res_valid=0, res_ovr=0.
REQ-030 CFS_BBOX_EN, sel_color=3, blue pixels at (10,5) and (150,100) only -> bb_xmin=10, bb_xmax=150, bb_ymin=5, bb_ymax=100, bb_valid=1; without macro all 0.
REQ-031 rst low at pixel 9000, released, 19201 writes after next vsync -> res_long=1, cnt total 19200, no result from aborted frame.

Source files
------------

// File: rtl/cfs_pkg.sv
// Shared constants, colour/state encodings and bounding-box payload for color_frame_stats.
package cfs_pkg;

    localparam int unsigned AW_DEF        = 15;
    localparam int unsigned FRAME_PIX_DEF = 19200;
    localparam int unsigned H_RES_DEF     = 160;
    localparam int unsigned V_RES         = 120;
    localparam int unsigned THR_DEF       = 4;
    localparam int unsigned CW            = 12;
    localparam int unsigned XW            = $clog2(H_RES_DEF);
    localparam int unsigned YW            = $clog2(V_RES);

    typedef enum logic [1:0] {
        COL_NONE  = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    typedef struct packed {
        logic [XW-1:0] xmin;
        logic [XW-1:0] xmax;
        logic [YW-1:0] ymin;
        logic [YW-1:0] ymax;
        logic          hit;
    } bbox_t;

    localparam bbox_t BBOX_EMPTY = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, hit: 1'b0};

    // Largest count wins, ties resolved red > green > blue; all-zero frame reports none.
    function automatic color_e dominant(input logic [31:0] r, input logic [31:0] g,
                                        input logic [31:0] b);
        if (r == 32'd0 && g == 32'd0 && b == 32'd0) return COL_NONE;
        if (r >= g && r >= b) return COL_RED;
        if (g >= b) return COL_GREEN;
        return COL_BLUE;
    endfunction

endpackage

// File: rtl/px_classify.sv
// Combinational pixel colour classifier: a channel dominates when it beats both others by THR.
module px_classify
    import cfs_pkg::*;
#(
    parameter int unsigned THR = THR_DEF
) (
    input  logic [CW-1:0] px_data_i,
    output color_e        color_c_o
);

    logic [4:0] r_c, g_c, b_c, thr_c;

    // Widen to 5 bits so channel + margin cannot wrap.
    assign r_c   = {1'b0, px_data_i[11:8]};
    assign g_c   = {1'b0, px_data_i[7:4]};
    assign b_c   = {1'b0, px_data_i[3:0]};
    assign thr_c = 5'(THR);

    always_comb begin
        color_c_o = COL_NONE;
        if (r_c >= g_c + thr_c && r_c >= b_c + thr_c) begin
            color_c_o = COL_RED;
        end else if (g_c >= r_c + thr_c && g_c >= b_c + thr_c) begin
            color_c_o = COL_GREEN;
        end else if (b_c >= r_c + thr_c && b_c >= g_c + thr_c) begin
            color_c_o = COL_BLUE;
        end
    end

endmodule

// File: rtl/color_frame_stats.sv
// Per-frame colour statistics for a camera pixel stream, published on each vsync rising edge.
// Define CFS_BBOX_EN to track the bounding box of pixels matching sel_color.
module color_frame_stats
    import cfs_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned FRAME_PIX = FRAME_PIX_DEF,
    parameter int unsigned H_RES     = H_RES_DEF,
    parameter int unsigned THR       = THR_DEF
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          px_vsync,
    input  logic          px_we,
    input  logic [CW-1:0] px_data,
    input  logic [1:0]    sel_color,
    input  logic          res_ack,
    output logic          res_valid,
    output logic [1:0]    res_color,
    output logic [AW-1:0] cnt_r,
    output logic [AW-1:0] cnt_g,
    output logic [AW-1:0] cnt_b,
    output logic          res_short,
    output logic          res_long,
    output logic          res_ovr,
    output logic [XW-1:0] bb_xmin,
    output logic [XW-1:0] bb_xmax,
    output logic [YW-1:0] bb_ymin,
    output logic [YW-1:0] bb_ymax,
    output logic          bb_valid
);

    state_e        state_q, state_d;
    logic          vs_q, vs_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [AW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic          long_q, long_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          res_valid_q, res_valid_d;
    color_e        res_color_q, res_color_d;
    logic [AW-1:0] res_r_q, res_r_d, res_g_q, res_g_d, res_b_q, res_b_d;
    logic          res_short_q, res_short_d;
    logic          res_long_q, res_long_d;
    logic          res_ovr_q, res_ovr_d;
`ifdef CFS_BBOX_EN
    bbox_t         bb_q, bb_d;
    bbox_t         res_bb_q, res_bb_d;
`endif

    logic          vs_rise_c;
    color_e        px_cls_c;

    px_classify #(.THR(THR)) u_classify (
        .px_data_i (px_data),
        .color_c_o (px_cls_c)
    );

    assign vs_rise_c = px_vsync & ~vs_q;

    always_comb begin
        state_d     = state_q;
        vs_d        = px_vsync;
        pix_d       = pix_q;
        acc_r_d     = acc_r_q;
        acc_g_d     = acc_g_q;
        acc_b_d     = acc_b_q;
        long_d      = long_q;
        x_d         = x_q;
        y_d         = y_q;
        res_valid_d = res_valid_q;
        res_color_d = res_color_q;
        res_r_d     = res_r_q;
        res_g_d     = res_g_q;
        res_b_d     = res_b_q;
        res_short_d = res_short_q;
        res_long_d  = res_long_q;
        res_ovr_d   = res_ovr_q;
`ifdef CFS_BBOX_EN
        bb_d        = bb_q;
        res_bb_d    = res_bb_q;
`endif

        case (state_q)
            ST_IDLE:    if (vs_rise_c) state_d = ST_ACCUM;
            ST_ACCUM:   if (vs_rise_c) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_ACCUM;
            default:    state_d = ST_IDLE;
        endcase

        // Publish the closed frame and restart accumulation from an empty frame.
        if (state_q == ST_PUBLISH) begin
            res_valid_d = 1'b1;
            res_ovr_d   = res_valid_q & ~res_ack;
            res_color_d = dominant(32'(acc_r_q), 32'(acc_g_q), 32'(acc_b_q));
            res_r_d     = acc_r_q;
            res_g_d     = acc_g_q;
            res_b_d     = acc_b_q;
            res_short_d = (pix_q < AW'(FRAME_PIX));
            res_long_d  = long_q;
            pix_d       = '0;
            acc_r_d     = '0;
            acc_g_d     = '0;
            acc_b_d     = '0;
            long_d      = 1'b0;
            x_d         = '0;
            y_d         = '0;
`ifdef CFS_BBOX_EN
            res_bb_d    = bb_q;
            bb_d        = BBOX_EMPTY;
`endif
        end else if (res_ack) begin
            res_valid_d = 1'b0;
            res_ovr_d   = 1'b0;
        end

        // A write during PUBLISH lands on the freshly cleared accumulators.
        if (state_q != ST_IDLE && px_we) begin
            if (pix_d < AW'(FRAME_PIX)) begin
                pix_d = pix_d + AW'(1);
                case (px_cls_c)
                    COL_RED:   acc_r_d = acc_r_d + AW'(1);
                    COL_GREEN: acc_g_d = acc_g_d + AW'(1);
                    COL_BLUE:  acc_b_d = acc_b_d + AW'(1);
                    default:   ;
                endcase
`ifdef CFS_BBOX_EN
                if (px_cls_c == color_e'(sel_color)) begin
                    if (x_d < bb_d.xmin) bb_d.xmin = x_d;
                    if (x_d > bb_d.xmax) bb_d.xmax = x_d;
                    if (y_d < bb_d.ymin) bb_d.ymin = y_d;
                    if (y_d > bb_d.ymax) bb_d.ymax = y_d;
                    bb_d.hit = 1'b1;
                end
`endif
                if (x_d == XW'(H_RES - 1)) begin
                    x_d = '0;
                    y_d = y_d + YW'(1);
                end else begin
                    x_d = x_d + XW'(1);
                end
            end else begin
                long_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CAM_pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            vs_q        <= 1'b0;
            pix_q       <= '0;
            acc_r_q     <= '0;
            acc_g_q     <= '0;
            acc_b_q     <= '0;
            long_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_color_q <= COL_NONE;
            res_r_q     <= '0;
            res_g_q     <= '0;
            res_b_q     <= '0;
            res_short_q <= 1'b0;
            res_long_q  <= 1'b0;
            res_ovr_q   <= 1'b0;
`ifdef CFS_BBOX_EN
            bb_q        <= BBOX_EMPTY;
            res_bb_q    <= BBOX_EMPTY;
`endif
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            pix_q       <= pix_d;
            acc_r_q     <= acc_r_d;
            acc_g_q     <= acc_g_d;
            acc_b_q     <= acc_b_d;
            long_q      <= long_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_valid_q <= res_valid_d;
            res_color_q <= res_color_d;
            res_r_q     <= res_r_d;
            res_g_q     <= res_g_d;
            res_b_q     <= res_b_d;
            res_short_q <= res_short_d;
            res_long_q  <= res_long_d;
            res_ovr_q   <= res_ovr_d;
`ifdef CFS_BBOX_EN
            bb_q        <= bb_d;
            res_bb_q    <= res_bb_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_color = res_color_q;
    assign cnt_r     = res_r_q;
    assign cnt_g     = res_g_q;
    assign cnt_b     = res_b_q;
    assign res_short = res_short_q;
    assign res_long  = res_long_q;
    assign res_ovr   = res_ovr_q;

`ifdef CFS_BBOX_EN
    assign bb_xmin  = res_bb_q.xmin;
    assign bb_xmax  = res_bb_q.xmax;
    assign bb_ymin  = res_bb_q.ymin;
    assign bb_ymax  = res_bb_q.ymax;
    assign bb_valid = res_bb_q.hit;
`else
    logic unused_sel_c;
    assign unused_sel_c = ^sel_color;
    assign bb_xmin  = '0;
    assign bb_xmax  = '0;
    assign bb_ymin  = '0;
    assign bb_ymax  = '0;
    assign bb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_color_frame_stats.sv
// Directed bench for color_frame_stats: table of short frames plus hand-written corner sequences.
module tb_color_frame_stats;

    localparam int AW = 15;

`ifdef CFS_BBOX_EN
    localparam int RST_XMIN = 255;
    localparam int RST_YMIN = 127;
    localparam int E_XMIN = 10, E_XMAX = 150, E_YMIN = 5, E_YMAX = 100, E_BBV = 1;
`else
    localparam int RST_XMIN = 0;
    localparam int RST_YMIN = 0;
    localparam int E_XMIN = 0, E_XMAX = 0, E_YMIN = 0, E_YMAX = 0, E_BBV = 0;
`endif

    logic          clk, rst, px_vsync, px_we, res_ack;
    logic [11:0]   px_data;
    logic [1:0]    sel_color;
    logic          res_valid, res_short, res_long, res_ovr, bb_valid;
    logic [1:0]    res_color;
    logic [AW-1:0] cnt_r, cnt_g, cnt_b;
    logic [7:0]    bb_xmin, bb_xmax;
    logic [6:0]    bb_ymin, bb_ymax;

    int n_vec = 0;
    int n_err = 0;

    color_frame_stats dut (
        .CAM_pclk  (clk),
        .rst       (rst),
        .px_vsync  (px_vsync),
        .px_we     (px_we),
        .px_data   (px_data),
        .sel_color (sel_color),
        .res_ack   (res_ack),
        .res_valid (res_valid),
        .res_color (res_color),
        .cnt_r     (cnt_r),
        .cnt_g     (cnt_g),
        .cnt_b     (cnt_b),
        .res_short (res_short),
        .res_long  (res_long),
        .res_ovr   (res_ovr),
        .bb_xmin   (bb_xmin),
        .bb_xmax   (bb_xmax),
        .bb_ymin   (bb_ymin),
        .bb_ymax   (bb_ymax),
        .bb_valid  (bb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] pa;
        int          na;
        logic [11:0] pb;
        int          nb;
        int          col;
        int          r;
        int          g;
        int          b;
        int          shrt;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [11:0] d, input int n);
        px_we   = 1'b1;
        px_data = d;
        repeat (n) tick();
        px_we   = 1'b0;
    endtask

    task automatic vs_pulse();
        px_vsync = 1'b1;
        tick();
        px_vsync = 1'b0;
        tick();
    endtask

    task automatic ack();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{12'h0F0, 50, 12'h00F, 50, 2, 0, 50, 50, 1};
        tbl[1] = '{12'h880, 3, 12'h840, 2, 1, 2, 0, 0, 1};
        tbl[2] = '{12'hF00, 5, 12'h0F0, 5, 1, 5, 5, 0, 1};
        tbl[3] = '{12'h0F0, 3, 12'h00F, 7, 3, 0, 3, 7, 1};
        tbl[4] = '{12'h000, 0, 12'h000, 0, 0, 0, 0, 0, 1};
        tbl[5] = '{12'h730, 4, 12'h740, 6, 1, 4, 0, 0, 1};
        tbl[6] = '{12'h0F4, 1, 12'hFFF, 9, 2, 0, 1, 0, 1};

        rst = 1'b0; px_vsync = 1'b0; px_we = 1'b0; px_data = '0;
        sel_color = 2'd3; res_ack = 1'b0;
        repeat (3) tick();
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_color", int'(res_color), 0);
        chk("rst_cnt_r", int'(cnt_r), 0);
        chk("rst_ovr", int'(res_ovr), 0);
        chk("rst_bb_xmin", int'(bb_xmin), RST_XMIN);
        chk("rst_bb_ymin", int'(bb_ymin), RST_YMIN);
        chk("rst_bb_valid", int'(bb_valid), 0);
        rst = 1'b1;
        tick();

        // Opening vsync from IDLE starts a frame without publishing.
        vs_pulse();
        chk("open_valid", int'(res_valid), 0);

        for (int i = 0; i < 7; i++) begin
            px(tbl[i].pa, tbl[i].na);
            px(tbl[i].pb, tbl[i].nb);
            vs_pulse();
            chk($sformatf("t%0d_valid", i), int'(res_valid), 1);
            chk($sformatf("t%0d_color", i), int'(res_color), tbl[i].col);
            chk($sformatf("t%0d_cnt_r", i), int'(cnt_r), tbl[i].r);
            chk($sformatf("t%0d_cnt_g", i), int'(cnt_g), tbl[i].g);
            chk($sformatf("t%0d_cnt_b", i), int'(cnt_b), tbl[i].b);
            chk($sformatf("t%0d_short", i), int'(res_short), tbl[i].shrt);
            chk($sformatf("t%0d_long", i), int'(res_long), 0);
            chk($sformatf("t%0d_ovr", i), int'(res_ovr), 0);
            ack();
            chk($sformatf("t%0d_acked", i), int'(res_valid), 0);
        end

        // Full red frame; result appears two edges after vsync is first sampled high.
        px(12'hF00, 19200);
        px_vsync = 1'b1;
        tick();
        chk("full_valid_early", int'(res_valid), 0);
        px_vsync = 1'b0;
        tick();
        chk("full_valid", int'(res_valid), 1);
        chk("full_color", int'(res_color), 1);
        chk("full_cnt_r", int'(cnt_r), 19200);
        chk("full_short", int'(res_short), 0);
        chk("full_long", int'(res_long), 0);
        ack();

        // Two publishes without ack: second overwrites and flags overrun.
        px(12'hF00, 3);
        vs_pulse();
        chk("ovr1_cnt_r", int'(cnt_r), 3);
        chk("ovr1_ovr", int'(res_ovr), 0);
        px(12'h0F0, 4);
        vs_pulse();
        chk("ovr2_cnt_g", int'(cnt_g), 4);
        chk("ovr2_cnt_r", int'(cnt_r), 0);
        chk("ovr2_color", int'(res_color), 2);
        chk("ovr2_ovr", int'(res_ovr), 1);
        ack();
        chk("ovr_ack_valid", int'(res_valid), 0);
        chk("ovr_ack_ovr", int'(res_ovr), 0);
        chk("ovr_ack_hold_g", int'(cnt_g), 4);
        ack();
        chk("idle_ack_valid", int'(res_valid), 0);

        // Ack coinciding with PUBLISH; pixels in the rise cycle and in PUBLISH.
        px(12'h00F, 2);
        vs_pulse();
        chk("pre_valid", int'(res_valid), 1);
        px(12'h00F, 3);
        px_vsync = 1'b1; px_we = 1'b1; px_data = 12'h00F;
        tick();
        px_vsync = 1'b0; res_ack = 1'b1; px_data = 12'hF00;
        tick();
        px_we = 1'b0; res_ack = 1'b0;
        chk("coin_valid", int'(res_valid), 1);
        chk("coin_ovr", int'(res_ovr), 0);
        chk("coin_cnt_b", int'(cnt_b), 4);
        chk("coin_color", int'(res_color), 3);
        ack();
        vs_pulse();
        chk("pub_px_cnt_r", int'(cnt_r), 1);
        chk("pub_px_cnt_b", int'(cnt_b), 0);
        chk("pub_px_color", int'(res_color), 1);
        ack();

        // Bounding box: blue at (10,5) and (150,100) only.
        px(12'h000, 810);
        px(12'h00F, 1);
        px(12'h000, 15339);
        px(12'h00F, 1);
        vs_pulse();
        chk("bb_cnt_b", int'(cnt_b), 2);
        chk("bb_color", int'(res_color), 3);
        chk("bb_xmin", int'(bb_xmin), E_XMIN);
        chk("bb_xmax", int'(bb_xmax), E_XMAX);
        chk("bb_ymin", int'(bb_ymin), E_YMIN);
        chk("bb_ymax", int'(bb_ymax), E_YMAX);
        chk("bb_valid", int'(bb_valid), E_BBV);
        ack();

        // Asynchronous reset mid-frame, then an over-long frame.
        px(12'h0F0, 9000);
        rst = 1'b0;
        #2;
        chk("mid_rst_cnt_b", int'(cnt_b), 0);
        chk("mid_rst_color", int'(res_color), 0);
        chk("mid_rst_bb_xmin", int'(bb_xmin), RST_XMIN);
        tick();
        rst = 1'b1;
        tick();
        px(12'h0F0, 50);
        vs_pulse();
        chk("abort_valid", int'(res_valid), 0);
        px(12'h00F, 19201);
        vs_pulse();
        chk("long_valid", int'(res_valid), 1);
        chk("long_flag", int'(res_long), 1);
        chk("long_cnt_b", int'(cnt_b), 19200);
        chk("long_cnt_g", int'(cnt_g), 0);
        chk("long_short", int'(res_short), 0);
        chk("long_color", int'(res_color), 3);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
